// File: rtl/adpll_bus_if.sv
// Register-bus bundle between the lock sequencer (master) and the adpll_ctr CPU port (slave).
interface adpll_bus_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [1:0]        rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/adpll_lock_seq.sv
// Hardware bring-up sequencer for the ADPLL: programs the channel, enables the loop,
// then polls lock status with a fixed idle gap until locked, timed out or aborted.
module adpll_lock_seq #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int ADDR_CH   = 0,
  parameter int ADDR_EN   = 1,
  parameter int ADDR_LOCK = 2,
  parameter int POLL_GAP  = 64,
  parameter int MAX_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] channel,
  adpll_bus_if.master       bus,
  output logic              busy,
  output logic              locked,
  output logic              timeout,
  output logic              aborted
);

  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_CH   = 3'd1;
  localparam logic [2:0] S_WR_EN   = 3'd2;
  localparam logic [2:0] S_RD_LOCK = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_OFF     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wstrb_q, wstrb_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;
  logic              aborted_q, aborted_d;
  logic [DATA_W-1:0] ch_q, ch_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              issue;
  logic [2:0]        issue_st;
  logic              abort_hit;
  logic              xfer_done;
  logic [POLL_W-1:0] poll_inc;

  assign poll_inc = poll_cnt_q + POLL_W'(1);

  always_comb begin
    // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
    state_d    = state_q;
    valid_d    = valid_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    aborted_d  = aborted_q;
    ch_d       = ch_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    issue      = 1'b0;
    issue_st   = state_q;
    // A latched abort stays pending until any outstanding transfer has completed.
    abort_hit  = abort | aborted_q;
    xfer_done  = valid_q & bus.ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR_CH;
          ch_d      = channel;
          busy_d    = 1'b1;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
        end
      end
      S_WR_CH, S_WR_EN, S_RD_LOCK: begin
        if (abort) aborted_d = 1'b1;
        if (!valid_q) begin
          if (abort_hit) state_d = S_OFF;
          else           issue   = 1'b1;
        end else if (xfer_done) begin
          valid_d = 1'b0;
          if (abort_hit) begin
            state_d = S_OFF;
          end else if (state_q == S_WR_CH) begin
            state_d = S_WR_EN;
          end else if (state_q == S_WR_EN) begin
            state_d    = S_RD_LOCK;
            poll_cnt_d = '0;
          end else begin
            poll_cnt_d = poll_inc;
            if (bus.rdata == 2'b01) begin
              state_d  = S_DONE;
              locked_d = 1'b1;
            end else if (poll_inc == POLL_W'(MAX_POLLS)) begin
              state_d   = S_OFF;
              timeout_d = 1'b1;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) aborted_d = 1'b1;
        if (abort_hit) begin
          state_d = S_OFF;
        end else if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
          // The read is launched on leaving the gap so reads are POLL_GAP+1 cycles apart.
          state_d  = S_RD_LOCK;
          issue    = 1'b1;
          issue_st = S_RD_LOCK;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_OFF: begin
        if (!valid_q) begin
          issue = 1'b1;
        end else if (xfer_done) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      valid_d = 1'b1;
      case (issue_st)
        S_WR_CH: begin
          address_d = ADDR_W'(ADDR_CH);
          wdata_d   = ch_q;
          wstrb_d   = 1'b1;
        end
        S_WR_EN: begin
          address_d = ADDR_W'(ADDR_EN);
          wdata_d   = DATA_W'(1);
          wstrb_d   = 1'b1;
        end
        S_RD_LOCK: begin
          address_d = ADDR_W'(ADDR_LOCK);
          wdata_d   = '0;
          wstrb_d   = 1'b0;
        end
        default: begin
          address_d = ADDR_W'(ADDR_EN);
          wdata_d   = '0;
          wstrb_d   = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      aborted_q  <= 1'b0;
      ch_q       <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      aborted_q  <= aborted_d;
      ch_q       <= ch_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.address = address_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_adpll_lock_seq.sv
// Self-checking bench for adpll_lock_seq: a bus responder logs every transfer and the
// log is compared with the transfer list and flags expected from the sequence rules.
module tb_adpll_lock_seq;

  localparam int POLL_GAP  = 3;
  localparam int MAX_POLLS = 4;

  typedef struct {
    logic        wstrb;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] channel;
  logic        busy, locked, timeout, aborted;

  adpll_bus_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  adpll_lock_seq #(
    .ADDR_W(5), .DATA_W(32), .ADDR_CH(0), .ADDR_EN(1), .ADDR_LOCK(2),
    .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .channel(channel),
    .bus(bus), .busy(busy), .locked(locked), .timeout(timeout), .aborted(aborted)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    start_cyc;
  int    delay   = 0;
  int    lock_at = 0;
  int    stable_err = 0;
  xfer_t log_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: ready after `delay` wait cycles; lock status 01 on read number lock_at.
  initial begin : responder
    int          wait_cnt;
    int          nreads;
    logic [4:0]  cap_addr;
    logic [31:0] cap_data;
    logic        cap_wstrb;
    wait_cnt  = 0;
    bus.ready = 1'b0;
    bus.rdata = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.valid) begin
        bus.ready = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (wait_cnt == 0) begin
          cap_addr = bus.address; cap_data = bus.wdata; cap_wstrb = bus.wstrb;
        end else if (bus.address !== cap_addr || bus.wdata !== cap_data ||
                     bus.wstrb !== cap_wstrb) begin
          stable_err++;
        end
        if (wait_cnt >= delay) begin
          bus.ready = 1'b1;
          if (!bus.wstrb) begin
            nreads = 0;
            foreach (log_q[i]) if (!log_q[i].wstrb) nreads++;
            if (nreads + 1 == lock_at) begin
              bus.rdata = 2'b01;
            end else begin
              case ($urandom_range(0, 2))
                0:       bus.rdata = 2'b00;
                1:       bus.rdata = 2'b10;
                default: bus.rdata = 2'b11;
              endcase
            end
          end
          log_q.push_back('{bus.wstrb, bus.address, bus.wdata, cyc});
          wait_cnt = 0;
        end else begin
          bus.ready = 1'b0;
          wait_cnt++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] ch, input logic with_abort);
    @(posedge clk); #1;
    channel   = ch;
    start     = 1'b1;
    abort     = with_abort;
    start_cyc = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    abort   = 1'b0;
    channel = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_budget"}, n < 3000, 1'b1);
  endtask

  // Expected transfers: channel write, enable write, N lock reads, and the switch-off
  // write unless the ADPLL locked without an abort.
  task automatic check_seq(input string tag, input logic [31:0] ch, input int lk_at,
                           input int abort_at);
    xfer_t exp_q[$];
    int    reads;
    bit    ab, lock_ok, lk;
    ab      = abort_at > 0;
    lock_ok = lk_at >= 1 && lk_at <= MAX_POLLS;
    reads   = ab ? abort_at : (lock_ok ? lk_at : MAX_POLLS);
    lk      = !ab && lock_ok;
    exp_q.push_back('{1'b1, 5'd0, ch, 0});
    exp_q.push_back('{1'b1, 5'd1, 32'd1, 0});
    for (int i = 0; i < reads; i++) exp_q.push_back('{1'b0, 5'd2, 32'd0, 0});
    if (!lk) exp_q.push_back('{1'b1, 5'd1, 32'd0, 0});
    check({tag, "_xfer_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_x%0d_wstrb", tag, i), log_q[i].wstrb, exp_q[i].wstrb);
      check($sformatf("%s_x%0d_addr", tag, i), log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wstrb)
        check($sformatf("%s_x%0d_wdata", tag, i), log_q[i].data, exp_q[i].data);
    end
    check({tag, "_locked"}, locked, lk);
    check({tag, "_timeout"}, timeout, !ab && !lock_ok);
    check({tag, "_aborted"}, aborted, ab);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, bus.valid, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, bus.valid, 1'b0);
    check({tag, "_address"}, bus.address, 5'd0);
    check({tag, "_wdata"}, bus.wdata, 32'd0);
    check({tag, "_wstrb"}, bus.wstrb, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_aborted"}, aborted, 1'b0);
  endtask

  initial begin : stimulus
    logic [31:0] ch;
    int          n;
    int          k;
    bit          hit;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; channel = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;

    // 1: lock on 3rd read, ready tied 1, plus an ignored start while busy.
    delay = 0; lock_at = 3; log_q.delete();
    pulse_start(32'h2A, 1'b0);
    @(posedge clk); #1; start = 1'b1; channel = 32'h55;
    @(posedge clk); #1; start = 1'b0;
    wait_idle("t1");
    check_seq("t1", 32'h2A, 3, 0);
    if (log_q.size() >= 5) begin
      check("t1_first_read_latency", log_q[2].cyc - start_cyc, 6);
      check("t1_read_spacing_a", log_q[3].cyc - log_q[2].cyc, POLL_GAP + 1);
      check("t1_read_spacing_b", log_q[4].cyc - log_q[3].cyc, POLL_GAP + 1);
    end

    // 2: never locks; start and abort together in IDLE, start is taken.
    lock_at = 0; log_q.delete(); ch = $urandom;
    pulse_start(ch, 1'b1);
    wait_idle("t2");
    check_seq("t2", ch, 0, 0);

    // 3: 5 wait cycles on each transfer; request must hold still while waiting.
    delay = 5; lock_at = 2; log_q.delete(); stable_err = 0; ch = $urandom;
    pulse_start(ch, 1'b0);
    wait_idle("t3");
    check_seq("t3", ch, 2, 0);
    check("t3_request_stable", stable_err, 0);

    // 4: abort somewhere inside the gap after the 2nd read.
    delay = 0; lock_at = 0; log_q.delete(); ch = $urandom;
    pulse_start(ch, 1'b0);
    n = 0;
    while (log_q.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t4_second_read_seen", log_q.size() >= 4, 1'b1);
    k = $urandom_range(0, POLL_GAP - 1);
    @(posedge clk);
    repeat (k) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_idle("t4");
    check_seq("t4", ch, 0, 2);

    // 5: abort in the same cycle as a completing read that reports lock.
    lock_at = 2; log_q.delete(); ch = $urandom; hit = 1'b0;
    pulse_start(ch, 1'b0);
    n = 0;
    while (!hit && n < 500) begin
      @(negedge clk); #1;
      n++;
      if (bus.ready && bus.valid && !bus.wstrb && bus.rdata == 2'b01) begin
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        hit = 1'b1;
      end
    end
    check("t5_abort_on_lock_read", hit, 1'b1);
    wait_idle("t5");
    check_seq("t5", ch, 2, 2);

    // 6: async reset while the enable write is waiting for ready.
    delay = 20; lock_at = 1; log_q.delete();
    pulse_start($urandom, 1'b0);
    n = 0;
    while (!(bus.valid && bus.address == 5'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_enable_write_seen", bus.valid && bus.address == 5'd1, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("t6_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    delay = 0; log_q.delete(); ch = $urandom;
    pulse_start(ch, 1'b0);
    wait_idle("t6");
    check_seq("t6", ch, 1, 0);

    // Randomised runs: lock read index (beyond MAX_POLLS means never), ready delay, channel.
    for (int r = 0; r < 5; r++) begin
      delay   = $urandom_range(0, 3);
      lock_at = $urandom_range(0, MAX_POLLS + 1);
      ch      = $urandom;
      log_q.delete();
      pulse_start(ch, 1'b0);
      wait_idle($sformatf("rnd%0d", r));
      check_seq($sformatf("rnd%0d", r), ch, lock_at, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
